cycle_stat_reader: RTL and testbench

Reads back the 64 x 32 opto-cycle statistics RAM (word 0 = opto-slot count per revolution, words 1..63 = clocks between successive opto rising edges) and serialises it as a big-endian byte stream, with a trailing checksum, to the W5500 transmit packet builder. On each request it also reports the minimum and maximum cycle count, used for motor-speed health checks. It sits between the statistics RAM read port and the Ethernet TX path, and is triggered by the host-command decoder.

---
 rtl/cycle_stat_pkg.sv | 39 +++
 rtl/cycle_stat_reader_byte_serializer.sv | 72 +++++++
 rtl/cycle_stat_reader.sv | 196 +++++++++++++++++++
 tb/tb_cycle_stat_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_stat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cycle_stat_pkg
// Description : Shared constants and FSM encoding for the opto-cycle
//               statistics read-back path.
// Revision    : 1.0 - initial release
// ============================================================================
package cycle_stat_pkg;

  // Statistics RAM geometry
  localparam int STAT_RAM_DEPTH = 64;
  localparam int ADDR_W         = 6;
  localparam int LEN_W          = 7;

  // Stream framing
  localparam int CS_BYTES       = 2;
  localparam int BYTES_PER_WORD = 4;

  // Min/max starting points so the first real sample always wins
  localparam logic [31:0] MIN_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] MAX_INIT = 32'h0000_0000;

  // Reader FSM encoding
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_RD_REQ    = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_WAIT   = 3'd2;
  localparam logic [STATE_W-1:0] ST_SEND_WORD = 3'd3;
  localparam logic [STATE_W-1:0] ST_SEND_CS   = 3'd4;
  localparam logic [STATE_W-1:0] ST_FINISH    = 3'd5;

  // Limit a requested word count to the RAM depth
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_stat_reader_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Shifts out up to 4 bytes of a left-justified word, MSB first,
//               one per valid/ready handshake, keeping a running 16-bit sum
//               of every accepted byte.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic [2:0]  i_count,
  input  logic        i_mark_last,
  input  logic        i_sum_clr,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_done,
  output logic [15:0] o_sum
);

  logic [31:0] r_shift;
  logic [2:0]  r_cnt;
  logic        r_valid;
  logic        r_mark_last;
  logic [15:0] r_sum;
  logic        w_hs;

  assign w_hs    = r_valid & i_ready;
  assign o_data  = r_shift[31:24];
  assign o_valid = r_valid;
  assign o_last  = r_valid & r_mark_last & (r_cnt == 3'd1);
  assign o_done  = w_hs & (r_cnt == 3'd1);
  assign o_sum   = r_sum;

  // Load a word, then advance one byte per handshake; data holds while stalled
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= 32'h0;
      r_cnt       <= 3'd0;
      r_valid     <= 1'b0;
      r_mark_last <= 1'b0;
    end else if (i_load) begin
      r_shift     <= i_word;
      r_cnt       <= i_count;
      r_valid     <= (i_count != 3'd0);
      r_mark_last <= i_mark_last;
    end else if (w_hs) begin
      r_shift <= {r_shift[23:0], 8'h00};
      r_cnt   <= r_cnt - 3'd1;
      if (r_cnt == 3'd1) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Running modulo-2^16 sum of every byte that actually left the block
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= 16'h0;
    end else if (i_sum_clr) begin
      r_sum <= 16'h0;
    end else if (w_hs) begin
      r_sum <= r_sum + {8'h00, r_shift[31:24]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/cycle_stat_reader.sv
`default_nettype none
// ============================================================================
// Module      : cycle_stat_reader
// Description : Reads the opto-cycle statistics RAM and streams it big-endian
//               with a trailing 16-bit checksum; reports min/max of the cycle
//               words (word 0, the slot count, is excluded).
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_stat_reader
  import cycle_stat_pkg::*;
#(
  parameter int RAM_DEPTH = STAT_RAM_DEPTH,
  parameter int RD_LAT    = 1
) (
  input  logic              i_clk_50m,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_ram_raddr,
  output logic              o_ram_ren,
  input  logic [31:0]       i_ram_rdata,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_tx_last,
  output logic [31:0]       o_min,
  output logic [31:0]       o_max,
  output logic              o_stat_valid
);

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(RD_LAT - 1);
  localparam logic [LEN_W-1:0]  C_LEN_MAX   = LEN_W'(RAM_DEPTH);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic [WAIT_W-1:0]  r_wait;
  logic [31:0]        r_word;
  logic [31:0]        r_min;
  logic [31:0]        r_max;

  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_start_ok;
  logic               w_wait_done;
  logic               w_more_words;
  logic               w_ser_load;
  logic [31:0]        w_ser_word;
  logic [2:0]         w_ser_count;
  logic               w_ser_mark_last;
  logic               w_ser_valid;
  logic               w_ser_done;
  logic [15:0]        w_sum;

  assign w_len_clamped = clamp_len(i_len, C_LEN_MAX);
  assign w_start_ok    = (r_state == ST_IDLE) & i_start;
  assign w_wait_done   = (r_wait == C_WAIT_LAST);
  assign w_more_words  = (r_idx + 7'd1) < r_len;

  assign o_ram_raddr   = r_idx[ADDR_W-1:0];
  assign o_min         = r_min;
  assign o_max         = r_max;

  // State register
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: one RAM read per word, then the checksum tail
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = (w_len_clamped == '0) ? ST_SEND_CS : ST_RD_REQ;
        end
      end
      ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (w_wait_done) begin
          w_state_nxt = ST_SEND_WORD;
        end
      end
      ST_SEND_WORD: begin
        if (w_ser_done) begin
          w_state_nxt = w_more_words ? ST_RD_REQ : ST_SEND_CS;
        end
      end
      ST_SEND_CS: begin
        if (w_ser_done) begin
          w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH:  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and serializer control decoded from the current state
  always_comb begin
    o_busy          = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    o_ram_ren       = 1'b0;
    o_done          = 1'b0;
    o_stat_valid    = 1'b0;
    w_ser_load      = 1'b0;
    w_ser_word      = 32'h0;
    w_ser_count     = 3'd0;
    w_ser_mark_last = 1'b0;
    case (r_state)
      ST_RD_REQ: o_ram_ren = 1'b1;
      ST_SEND_WORD: begin
        // Load on the first cycle here; the serializer stays valid until done
        w_ser_load  = ~w_ser_valid;
        w_ser_word  = r_word;
        w_ser_count = 3'(BYTES_PER_WORD);
      end
      ST_SEND_CS: begin
        w_ser_load      = ~w_ser_valid;
        w_ser_word      = {w_sum, 16'h0000};
        w_ser_count     = 3'(CS_BYTES);
        w_ser_mark_last = 1'b1;
      end
      ST_FINISH: begin
        o_done       = 1'b1;
        o_stat_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Request bookkeeping: length, word index, read-latency wait, captured word
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_wait <= '0;
      r_word <= 32'h0;
    end else begin
      if (w_start_ok) begin
        r_len <= w_len_clamped;
        r_idx <= '0;
      end else if ((r_state == ST_SEND_WORD) && w_ser_done) begin
        r_idx <= r_idx + 7'd1;
      end
      if (r_state == ST_RD_REQ) begin
        r_wait <= '0;
      end else if ((r_state == ST_RD_WAIT) && !w_wait_done) begin
        r_wait <= r_wait + 1'b1;
      end
      if ((r_state == ST_RD_WAIT) && w_wait_done) begin
        r_word <= i_ram_rdata;
      end
    end
  end

  // Unsigned min/max over cycle words; word 0 holds the slot count, not a cycle
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_min <= MIN_INIT;
      r_max <= MAX_INIT;
    end else if (w_start_ok) begin
      r_min <= MIN_INIT;
      r_max <= MAX_INIT;
    end else if ((r_state == ST_RD_WAIT) && w_wait_done && (r_idx != '0)) begin
      if (i_ram_rdata < r_min) r_min <= i_ram_rdata;
      if (i_ram_rdata > r_max) r_max <= i_ram_rdata;
    end
  end

  byte_serializer u_ser (
    .i_clk_50m   (i_clk_50m),
    .i_rst_n     (i_rst_n),
    .i_load      (w_ser_load),
    .i_word      (w_ser_word),
    .i_count     (w_ser_count),
    .i_mark_last (w_ser_mark_last),
    .i_sum_clr   (w_start_ok),
    .i_ready     (i_tx_ready),
    .o_data      (o_tx_data),
    .o_valid     (w_ser_valid),
    .o_last      (o_tx_last),
    .o_done      (w_ser_done),
    .o_sum       (w_sum)
  );

  assign o_tx_valid = w_ser_valid;

endmodule
`default_nettype wire

// File: tb/tb_cycle_stat_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cycle_stat_reader
// Description : Self-checking bench for cycle_stat_reader with a RAM model
//               and a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_stat_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [6:0]  i_len = 7'd0;
  logic        o_busy, o_done, o_ram_ren, o_tx_valid, o_tx_last, o_stat_valid;
  logic [5:0]  o_ram_raddr;
  logic [31:0] ram_q = 32'h0;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready = 1'b1;
  logic [31:0] o_min, o_max;

  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;

  // Reference results
  logic [7:0]  exp_q[$];
  logic [31:0] exp_min, exp_max;
  // Captured results
  logic [7:0]  got_q[$];
  int          last_cnt, last_pos, hold_err;
  logic [31:0] done_min, done_max;
  logic        done_stat, done_busy, done_seen;

  always #10 clk = ~clk;

  // Statistics RAM read port, one-cycle latency
  always @(posedge clk) begin
    if (o_ram_ren) ram_q <= mem[o_ram_raddr];
  end

  cycle_stat_reader #(.RAM_DEPTH(64), .RD_LAT(1)) dut (
    .i_clk_50m    (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_ram_raddr  (o_ram_raddr),
    .o_ram_ren    (o_ram_ren),
    .i_ram_rdata  (ram_q),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_tx_last    (o_tx_last),
    .o_min        (o_min),
    .o_max        (o_max),
    .o_stat_valid (o_stat_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic load_pat(input int p);
    for (int i = 0; i < 64; i++) mem[i] = (i == 0) ? 32'd60 : 32'(1000 + i);
    if (p == 1) begin
      mem[1] = 32'hFFFF_FFF0;
      mem[2] = 32'h0000_0001;
      mem[3] = 32'h8000_0000;
    end else if (p == 2) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
    end
  endtask

  // Packet-level model: big-endian words, byte sum mod 2^16, min/max of words 1..L-1
  task automatic build_model(input int len_in);
    int L;
    int unsigned s;
    L = (len_in > 64) ? 64 : len_in;
    s = 0;
    exp_q.delete();
    exp_min = 32'hFFFF_FFFF;
    exp_max = 32'h0;
    for (int w = 0; w < L; w++) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(mem[w][8*b +: 8]);
        s += mem[w][8*b +: 8];
      end
      if (w >= 1) begin
        if (mem[w] < exp_min) exp_min = mem[w];
        if (mem[w] > exp_max) exp_max = mem[w];
      end
    end
    s = s % 65536;
    exp_q.push_back(8'(s >> 8));
    exp_q.push_back(8'(s));
  endtask

  // Issue a start and collect the stream until o_done (or abort after N bytes)
  task automatic run_dump(input int len_in, input bit rnd, input int restart_at,
                          input int abort_after);
    int   cyc;
    logic prev_hold;
    logic [7:0] prev_data;
    got_q.delete();
    last_cnt = 0; last_pos = -1; hold_err = 0; done_seen = 1'b0;
    done_stat = 1'b0; done_busy = 1'b1; done_min = 32'h0; done_max = 32'h0;
    prev_hold = 1'b0; prev_data = 8'h0;
    @(negedge clk);
    i_start = 1'b1;
    i_len = 7'(len_in);
    i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    while (!done_seen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      i_start = (cyc == restart_at);
      if (cyc == restart_at) i_len = 7'd3;
      if (prev_hold && (!o_tx_valid || o_tx_data !== prev_data)) hold_err++;
      if (o_done) begin
        done_seen = 1'b1;
        done_stat = o_stat_valid;
        done_busy = o_busy;
        done_min  = o_min;
        done_max  = o_max;
      end
      i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_tx_valid && i_tx_ready) begin
        got_q.push_back(o_tx_data);
        if (o_tx_last) begin
          last_cnt++;
          last_pos = got_q.size();
        end
      end
      prev_hold = o_tx_valid && !i_tx_ready;
      prev_data = o_tx_data;
      if (abort_after > 0 && got_q.size() >= abort_after) break;
    end
    i_start = 1'b0;
    i_tx_ready = 1'b1;
  endtask

  task automatic check_dump(input string tag);
    int mism;
    mism = 0;
    check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_byte_mismatches"}, 32'(mism), 32'd0);
    check({tag, "_last_count"}, 32'(last_cnt), 32'd1);
    check({tag, "_last_pos"}, 32'(last_pos), 32'(exp_q.size()));
    check({tag, "_hold_violations"}, 32'(hold_err), 32'd0);
    check({tag, "_stat_valid"}, 32'(done_stat), 32'd1);
    check({tag, "_busy_at_done"}, 32'(done_busy), 32'd0);
    check({tag, "_min"}, done_min, exp_min);
    check({tag, "_max"}, done_max, exp_max);
  endtask

  typedef struct {
    int          len;
    bit          rnd;
    int          pat;
    int          restart;
    int          exp_n;
    logic [31:0] exp_min;
    logic [31:0] exp_max;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic b_busy[16], b_ren[16], b_valid[16], b_done[16], b_last[16];
    logic [7:0] first4[4];

    vecs[0] = '{64,  1'b0, 0, -1, 258, 32'd1001,      32'd1063};
    vecs[1] = '{0,   1'b0, 0, -1, 2,   32'hFFFF_FFFF, 32'd0};
    vecs[2] = '{5,   1'b0, 0, -1, 22,  32'd1001,      32'd1004};
    vecs[3] = '{5,   1'b1, 0, -1, 22,  32'd1001,      32'd1004};
    vecs[4] = '{100, 1'b0, 0, 40, 258, 32'd1001,      32'd1063};
    vecs[5] = '{1,   1'b1, 0, -1, 6,   32'hFFFF_FFFF, 32'd0};
    vecs[6] = '{4,   1'b1, 1, -1, 18,  32'd1,         32'hFFFF_FFF0};
    vecs[7] = '{64,  1'b1, 1, 100, 258, 32'd1,        32'hFFFF_FFF0};

    load_pat(0);
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_ren", 32'(o_ram_ren), 32'd0);
    check("rst_valid", 32'(o_tx_valid), 32'd0);
    check("rst_last", 32'(o_tx_last), 32'd0);
    check("rst_stat", 32'(o_stat_valid), 32'd0);
    check("rst_raddr", 32'(o_ram_raddr), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    check("rst_min", o_min, 32'hFFFF_FFFF);
    check("rst_max", o_max, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cycle-accurate timing of a one-word dump with ready high
    @(negedge clk);
    i_start = 1'b1; i_len = 7'd1; i_tx_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      b_busy[k] = o_busy; b_ren[k] = o_ram_ren; b_valid[k] = o_tx_valid;
      b_done[k] = o_done; b_last[k] = o_tx_last;
    end
    check("t_busy_c1", 32'(b_busy[1]), 32'd1);
    check("t_ren_c1", 32'(b_ren[1]), 32'd1);
    check("t_ren_c2", 32'(b_ren[2]), 32'd0);
    check("t_valid_c3", 32'(b_valid[3]), 32'd0);
    check("t_valid_c4", 32'(b_valid[4]), 32'd1);
    check("t_last_c9", 32'(b_last[9]), 32'd0);
    check("t_last_c10", 32'(b_last[10]), 32'd1);
    check("t_done_c10", 32'(b_done[10]), 32'd0);
    check("t_done_c11", 32'(b_done[11]), 32'd1);
    check("t_busy_c10", 32'(b_busy[10]), 32'd1);
    check("t_busy_c11", 32'(b_busy[11]), 32'd0);
    check("t_done_c12", 32'(b_done[12]), 32'd0);

    // Table-driven directed vectors
    for (int v = 0; v < 8; v++) begin
      load_pat(vecs[v].pat);
      build_model(vecs[v].len);
      run_dump(vecs[v].len, vecs[v].rnd, vecs[v].restart, 0);
      check($sformatf("v%0d_nbytes_tbl", v), 32'(got_q.size()), 32'(vecs[v].exp_n));
      check($sformatf("v%0d_min_tbl", v), done_min, vecs[v].exp_min);
      check($sformatf("v%0d_max_tbl", v), done_max, vecs[v].exp_max);
      check_dump($sformatf("v%0d", v));
      if (v == 0) begin
        for (int i = 0; i < 4; i++) first4[i] = (got_q.size() > i) ? got_q[i] : 8'hXX;
        check("v0_first_bytes", {first4[0], first4[1], first4[2], first4[3]}, 32'h0000_003C);
      end
      if (v == 1) begin
        check("v1_cs_bytes", 32'((got_q.size() == 2) ? {got_q[0], got_q[1]} : 16'hDEAD), 32'h0);
      end
    end

    // Reset in the middle of word 3, then a full clean dump
    load_pat(0);
    run_dump(64, 1'b0, -1, 13);
    rst_n = 1'b0;
    #1;
    check("ab_busy", 32'(o_busy), 32'd0);
    check("ab_valid", 32'(o_tx_valid), 32'd0);
    check("ab_last", 32'(o_tx_last), 32'd0);
    check("ab_ren", 32'(o_ram_ren), 32'd0);
    check("ab_raddr", 32'(o_ram_raddr), 32'd0);
    check("ab_data", 32'(o_tx_data), 32'd0);
    check("ab_min", o_min, 32'hFFFF_FFFF);
    check("ab_max", o_max, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_model(64);
    run_dump(64, 1'b1, -1, 0);
    check_dump("after_rst");

    // Randomized contents and lengths against the model
    for (int r = 0; r < 6; r++) begin
      int len;
      load_pat(2);
      len = $urandom_range(0, 72);
      build_model(len);
      run_dump(len, 1'b1, -1, 0);
      check_dump($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
